// File: rtl/vram_arbiter.sv
// Single-port board RAM arbiter: display reads win (2-cycle read latency); game writes are buffered and drained in idle slots.
// Writes are acked one cycle after acceptance and refused while the buffer is full; VRAM_ARB_VBLANK_ONLY_EN restricts draining to vblank.
module vram_arbiter #(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 4,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset_n,
   input  logic                          disp_req,
   input  logic [ADDR_W-1:0]             disp_addr,
   output logic [DATA_W-1:0]             disp_data,
   output logic                          disp_valid,
   input  logic                          wr_req,
   input  logic [ADDR_W-1:0]             wr_addr,
   input  logic [DATA_W-1:0]             wr_data,
   output logic                          wr_ack,
   input  logic                          vblank,
   output logic                          ram_en,
   output logic                          ram_we,
   output logic [ADDR_W-1:0]             ram_addr,
   output logic [DATA_W-1:0]             ram_wdata,
   input  logic [DATA_W-1:0]             ram_rdata,
   output logic                          fifo_full,
   output logic [$clog2(FIFO_DEPTH):0]   pending
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int ENT_W = ADDR_W + DATA_W;

   typedef enum logic [1:0] {IDLE = 2'd0, RD = 2'd1, WR = 2'd2} op_t;

   op_t              state;
   logic [ENT_W-1:0] wbuf [FIFO_DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             disp_vld_q;
   logic             pop_gate;
   logic             fifo_empty;
   logic             pop;
   logic             push;

   assign fifo_full  = (pending == CNT_W'(FIFO_DEPTH));
   assign fifo_empty = (pending == '0);

`ifdef VRAM_ARB_VBLANK_ONLY_EN
   assign pop_gate = vblank;
`else
   logic unused_vblank;
   assign unused_vblank = vblank;
   assign pop_gate      = 1'b1;
`endif

   // A pop frees a slot in the same cycle, so a full buffer can still accept
   assign pop  = !disp_req && !fifo_empty && pop_gate;
   assign push = wr_req && (!fifo_full || pop);

   // RAM data arrives combinationally in the cycle after the RD op
   assign disp_valid = disp_vld_q;
   assign disp_data  = disp_vld_q ? ram_rdata : '0;

   always_ff @(posedge clk) begin
      if (push) begin
         wbuf[wr_ptr] <= {wr_addr, wr_data};
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state      <= IDLE;
         ram_en     <= 1'b0;
         ram_we     <= 1'b0;
         ram_addr   <= '0;
         ram_wdata  <= '0;
         disp_vld_q <= 1'b0;
         wr_ack     <= 1'b0;
         pending    <= '0;
         rd_ptr     <= '0;
         wr_ptr     <= '0;
      end else begin
         wr_ack     <= push;
         disp_vld_q <= (state == RD);
         pending    <= pending + CNT_W'(push) - CNT_W'(pop);
         if (push) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         if (disp_req) begin
            state    <= RD;
            ram_en   <= 1'b1;
            ram_we   <= 1'b0;
            ram_addr <= disp_addr;
         end else if (pop) begin
            state                 <= WR;
            ram_en                <= 1'b1;
            ram_we                <= 1'b1;
            {ram_addr, ram_wdata} <= wbuf[rd_ptr];
         end else begin
            state  <= IDLE;
            ram_en <= 1'b0;
            ram_we <= 1'b0;
         end
      end
   end
endmodule

// File: tb/tb_vram_arbiter.sv
// Randomized bench for vram_arbiter against a queue-based model of the write buffer and board RAM.
module tb_vram_arbiter;
   localparam int AW    = 9;
   localparam int DW    = 4;
   localparam int DEPTH = 4;
   localparam int CW    = 3;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          disp_req;
   logic [AW-1:0] disp_addr;
   logic [DW-1:0] disp_data;
   logic          disp_valid;
   logic          wr_req;
   logic [AW-1:0] wr_addr;
   logic [DW-1:0] wr_data;
   logic          wr_ack;
   logic          vblank;
   logic          ram_en;
   logic          ram_we;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_rdata;
   logic          fifo_full;
   logic [CW-1:0] pending;

   always #5 clk = ~clk;

   vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
      .clk(clk), .reset_n(reset_n),
      .disp_req(disp_req), .disp_addr(disp_addr), .disp_data(disp_data), .disp_valid(disp_valid),
      .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
      .vblank(vblank),
      .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .fifo_full(fifo_full), .pending(pending)
   );

   function automatic logic [DW-1:0] init_val(int a);
      return DW'((a * 3 + 4) % 10);
   endfunction

   // Board RAM: one-cycle read latency, single port
   logic [DW-1:0] ram [512];
   initial begin
      for (int i = 0; i < 512; i++) ram[i] = init_val(i);
      ram_rdata = '0;
      forever begin
         @(posedge clk);
         if (ram_en) begin
            if (ram_we) ram[ram_addr] = ram_wdata;
            else        ram_rdata     = ram[ram_addr];
         end
      end
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: queue of accepted writes and the contents the RAM should hold
   typedef struct packed {logic [AW-1:0] a; logic [DW-1:0] d;} ent_t;
   ent_t          q[$];
   logic [DW-1:0] mref [512];
   int            op_cur = 0;   // 0 none, 1 read, 2 write issued this cycle
   logic [AW-1:0] op_addr = '0;
   logic [DW-1:0] op_data = '0;
   logic          last_ack = 1'b0;

   task automatic step();
      logic          nv;
      logic [DW-1:0] nd;
      logic          pop, push, gate, e_vld, in_rst;
      logic [DW-1:0] e_dat;
      ent_t          e;
      @(posedge clk);
      nv = 1'b0;
      nd = '0;
      if (op_cur == 2) mref[op_addr] = op_data;
      if (op_cur == 1) begin nv = 1'b1; nd = mref[op_addr]; end
      in_rst = !reset_n;
      if (in_rst) begin
         q.delete();
         op_cur = 0;
         push   = 1'b0;
         e_vld  = 1'b0;
         e_dat  = '0;
      end else begin
`ifdef VRAM_ARB_VBLANK_ONLY_EN
         gate = vblank;
`else
         gate = 1'b1;
`endif
         pop  = !disp_req && (q.size() > 0) && gate;
         push = wr_req && ((q.size() < DEPTH) || pop);
         if (disp_req) begin
            op_cur  = 1;
            op_addr = disp_addr;
         end else if (pop) begin
            e       = q.pop_front();
            op_cur  = 2;
            op_addr = e.a;
            op_data = e.d;
         end else begin
            op_cur = 0;
         end
         if (push) q.push_back({wr_addr, wr_data});
         e_vld = nv;
         e_dat = nv ? nd : '0;
      end
      last_ack = push;
      #1;
      chk("ram_en", ram_en, op_cur != 0);
      chk("ram_we", ram_we, op_cur == 2);
      chk("wr_ack", wr_ack, push);
      chk("pending", pending, q.size());
      chk("fifo_full", fifo_full, q.size() == DEPTH);
      chk("disp_valid", disp_valid, e_vld);
      if (in_rst) begin
         chk("rst_ram_addr", ram_addr, 0);
         chk("rst_ram_wdata", ram_wdata, 0);
         chk("rst_disp_data", disp_data, 0);
      end else begin
         if (op_cur != 0) chk("ram_addr", ram_addr, op_addr);
         if (op_cur == 2) chk("ram_wdata", ram_wdata, op_data);
         if (e_vld)       chk("disp_data", disp_data, e_dat);
      end
   endtask

   task automatic push_one(input int a, input int d);
      wr_req  = 1'b1;
      wr_addr = AW'(a);
      wr_data = DW'(d);
      step();
      wr_req  = 1'b0;
   endtask

   initial begin
      int nbad;
      int dprob;
      for (int i = 0; i < 512; i++) mref[i] = init_val(i);
      reset_n = 1'b0; disp_req = 1'b0; disp_addr = '0; vblank = 1'b0;
      wr_req = 1'b1; wr_addr = 9'd5; wr_data = 4'd7;
      repeat (3) step();
      chk("reset_pending", pending, 0);
      reset_n = 1'b1; wr_req = 1'b0;
      step();

      // Read latency
      disp_req = 1'b1; disp_addr = 9'd37;
      step();
      chk("rd37_addr", ram_addr, 37);
      disp_req = 1'b0;
      step();
      chk("rd37_valid", disp_valid, 1);
      chk("rd37_data", disp_data, 5);
      step();

      // Buffered writes under continuous display reads
      disp_req = 1'b1;
      for (int i = 0; i < 4; i++) begin
         disp_addr = AW'($urandom_range(0, 199));
         push_one(i, i + 1);
      end
      chk("buf_full", fifo_full, 1);
      wr_req = 1'b1; wr_addr = 9'd9; wr_data = 4'd9;
      step(); step();
      chk("fifth_no_ack", wr_ack, 0);
      wr_req = 1'b0; disp_req = 1'b0; vblank = 1'b1;
      repeat (6) step();
      chk("drained", pending, 0);
      for (int i = 0; i < 4; i++) chk("wr_order_mem", mref[i], i + 1);

      // Push and pop together while full
      disp_req = 1'b1;
      for (int i = 0; i < 4; i++) push_one(40 + i, i + 5);
      disp_req = 1'b0; wr_req = 1'b1; wr_addr = 9'd50; wr_data = 4'd9;
      step();
      chk("sim_ack", wr_ack, 1);
      chk("sim_pending", pending, 4);
      wr_req = 1'b0;
      repeat (6) step();

      // Drain gated by vblank (only when the option is built in)
      disp_req = 1'b1;
      push_one(60, 3); push_one(61, 4);
      disp_req = 1'b0; vblank = 1'b0;
      repeat (10) step();
      vblank = 1'b1;
      repeat (3) step();
      chk("vb_drained", pending, 0);

      // Reset with buffered writes outstanding
      disp_req = 1'b1;
      push_one(70, 1); push_one(71, 2); push_one(72, 3);
      reset_n = 1'b0; disp_req = 1'b0;
      step();
      reset_n = 1'b1;
      repeat (5) step();
      chk("mid_rst_ram70", ram[70], init_val(70));

      // Randomized traffic with a well-behaved write requester
      dprob = 50;
      for (int c = 0; c < 3000; c++) begin
         if (c % 200 == 0) dprob = $urandom_range(0, 95);
         if (!wr_req || last_ack) begin
            wr_req  = ($urandom_range(0, 99) < 60);
            wr_addr = AW'($urandom_range(0, 199));
            wr_data = DW'($urandom_range(0, 9));
         end
         disp_req  = ($urandom_range(0, 99) < dprob);
         disp_addr = AW'($urandom_range(0, 199));
         vblank    = $urandom_range(0, 1) == 1;
         reset_n   = ($urandom_range(0, 999) != 0);
         step();
      end
      reset_n = 1'b1; wr_req = 1'b0; disp_req = 1'b0; vblank = 1'b1;
      repeat (8) step();
      nbad = 0;
      for (int i = 0; i < 200; i++) if (ram[i] !== mref[i]) nbad++;
      chk("ram_contents", nbad, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 9, board-cell RAM address width (20x10 cells, addr = y*10+x).
REQ-002 SHALL have parameter DATA_W, default 4, cell data width (block kind 0-9).
REQ-003 SHALL have parameter FIFO_DEPTH, default 4, write-buffer entries (power of two, >= 2).
REQ-004 SHALL have port clk, input, 1, rising-edge clock.
REQ-005 SHALL have port reset_n, input, 1, synchronous, active-low reset.
REQ-006 SHALL have port disp_req, input, 1, display pixel-pipeline read request.
REQ-007 SHALL have port disp_addr, input, ADDR_W, display read address.
REQ-008 SHALL have port disp_data, output, DATA_W, display read data.
REQ-009 SHALL have port disp_valid, output, 1, disp_data valid strobe.
REQ-010 SHALL have port wr_req, input, 1, game-logic write request.
REQ-011 SHALL have ports wr_addr (input, ADDR_W) and wr_data (input, DATA_W), write address and cell value.
REQ-012 SHALL have port wr_ack, output, 1, write-accepted pulse.
REQ-013 SHALL have port vblank, input, 1, vertical-blank indicator from the VGA sync generator.
REQ-014 SHALL have ports ram_en and ram_we, outputs, 1 each, single-port RAM enable and write enable.
REQ-015 SHALL have ports ram_addr (output, ADDR_W) and ram_wdata (output, DATA_W), RAM address and write data.
REQ-016 SHALL have port ram_rdata, input, DATA_W, RAM read data, one-cycle read latency.
REQ-017 SHALL have ports fifo_full (output, 1) and pending (output, $clog2(FIFO_DEPTH)+1), buffer status.

Function
REQ-018 SHALL hold a registered op state in {IDLE, RD, WR}, naming the RAM op issued in the current cycle.
REQ-019 SHALL give the display absolute priority: if disp_req=1 at cycle N, state=RD, ram_en=1, ram_we=0, ram_addr=disp_addr at N+1.
REQ-020 SHALL assert disp_valid at N+2 with disp_data=ram_rdata; fixed read latency of 2 cycles, with one read per cycle sustained.
REQ-021 SHALL accept a write when wr_req=1 and fifo_full=0, pushing {wr_addr,wr_data}, and pulse wr_ack for exactly one cycle at N+1.
REQ-022 SHALL ignore wr_req while fifo_full=1: no push and no wr_ack; the requester holds wr_req until acked.
REQ-023 SHALL pop one FIFO entry when disp_req=0 and FIFO is non-empty; then state=WR, ram_en=1, ram_we=1, ram_addr/ram_wdata = entry at N+1.
REQ-024 SHALL issue no RAM op at N+1 (state=IDLE, ram_en=0, ram_we=0) when disp_req=0 and FIFO is empty.
REQ-025 SHALL, on simultaneous push and pop in one cycle, leave pending unchanged, and SHALL allow the push when full only if a pop occurs in the same cycle.
REQ-026 SHALL drain the FIFO in strict FIFO order; writes to the same address land in acceptance order.
REQ-027 SHALL wrap read and write pointers modulo FIFO_DEPTH; pending SHALL range 0..FIFO_DEPTH, and fifo_full = (pending==FIFO_DEPTH).
REQ-028 SHALL NOT forward buffered data to display reads; a read of a pending address returns the old RAM value.

Reset
REQ-029 SHALL, while reset_n=0 at a clock edge, set state=IDLE, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, disp_valid=0, disp_data=0, wr_ack=0, pending=0, pointers=0, fifo_full=0.
REQ-030 SHALL discard buffered, unwritten entries on reset mid-operation; an in-flight read SHALL produce no disp_valid after reset.

Configuration
REQ-031 SHALL support macro VRAM_ARB_VBLANK_ONLY_EN: when defined, a FIFO pop additionally requires vblank=1, so board writes never land mid-frame.
REQ-032 SHALL, when VRAM_ARB_VBLANK_ONLY_EN is undefined, ignore vblank; pops depend only on disp_req=0 and a non-empty FIFO.

Verification
REQ-033 Reset: hold reset_n=0 for 3 cycles with wr_req=1 -> all outputs 0, no wr_ack, pending=0.
REQ-034 Read latency: disp_req=1, disp_addr=37, RAM[37]=5 -> ram_addr=37 at N+1; disp_valid=1 and disp_data=5 at N+2.
REQ-035 Buffered write: disp_req=1 continuous; 4 writes (addr 0..3, data 1..4) -> 4 wr_acks, fifo_full=1; 5th wr_req gets no ack; disp_req=0 -> 4 WR ops in order, pending 4->0.
REQ-036 Simultaneous events: FIFO full, disp_req=0, wr_req=1 same cycle -> pop and push both occur, wr_ack pulses, pending stays 4.
REQ-037 Config: with VRAM_ARB_VBLANK_ONLY_EN, pending=2, disp_req=0, vblank=0 -> no WR for 10 cycles; vblank=1 -> 2 WR ops in 2 cycles. Without the macro, the same stimulus drains immediately.
REQ-038 Mid-op reset: pending=3, reset_n=0 for 1 cycle -> pending=0, no further WR ops, RAM unchanged.
